// File: rtl/calc1_top.sv
// rtl/calc1_top.sv - four-port calculator with shared add/sub and shift units
// Spec bit 0 (MSB) maps to [31] here; shift amount op2[27:31] is op2[4:0].
module calc1_top (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req1_cmd_in,
    input  logic [3:0]  req2_cmd_in,
    input  logic [3:0]  req3_cmd_in,
    input  logic [3:0]  req4_cmd_in,
    input  logic [31:0] req1_data_in,
    input  logic [31:0] req2_data_in,
    input  logic [31:0] req3_data_in,
    input  logic [31:0] req4_data_in,
    output logic [1:0]  out_resp1,
    output logic [1:0]  out_resp2,
    output logic [1:0]  out_resp3,
    output logic [1:0]  out_resp4,
    output logic [31:0] out_data1,
    output logic [31:0] out_data2,
    output logic [31:0] out_data3,
    output logic [31:0] out_data4
);

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    typedef enum logic [1:0] {S_IDLE, S_OP2, S_DLY, S_ARB} state_t;

    state_t      state_q [4];
    state_t      state_d [4];
    logic [3:0]  cmd_q   [4];
    logic [31:0] op1_q   [4];
    logic [31:0] op2_q   [4];
    logic [1:0]  resp_q  [4];
    logic [1:0]  resp_d  [4];
    logic [31:0] data_q  [4];
    logic [31:0] data_d  [4];
    logic [3:0]  cmd_in  [4];
    logic [31:0] data_in [4];
    logic [3:0]  req_as, req_sh, gnt_as, gnt_sh, done;

    assign cmd_in  = '{req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in};
    assign data_in = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};

    function automatic logic [33:0] execute(input logic [3:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] sum;
        logic [33:0] r;
        sum = {1'b0, a} + {1'b0, b};
        case (cmd)
            CMD_ADD: r = sum[32] ? {2'd2, 32'd0} : {2'd1, sum[31:0]};
            CMD_SUB: r = (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            CMD_SHL: r = {2'd1, a << b[4:0]};
            CMD_SHR: r = {2'd1, a >> b[4:0]};
            default: r = {2'd3, 32'd0};
        endcase
        return r;
    endfunction

    // Fixed-priority grant per unit; invalid commands bypass arbitration.
    always_comb begin
        req_as = '0;
        req_sh = '0;
        gnt_as = '0;
        gnt_sh = '0;
        done   = '0;
        for (int i = 0; i < 4; i++) begin
            req_as[i] = (state_q[i] == S_ARB) && (cmd_q[i] == CMD_ADD || cmd_q[i] == CMD_SUB);
            req_sh[i] = (state_q[i] == S_ARB) && (cmd_q[i] == CMD_SHL || cmd_q[i] == CMD_SHR);
        end
        for (int i = 0; i < 4; i++) begin
            if (req_as[i] && (gnt_as == 4'd0)) gnt_as[i] = 1'b1;
            if (req_sh[i] && (gnt_sh == 4'd0)) gnt_sh[i] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            done[i] = (state_q[i] == S_ARB) && (gnt_as[i] || gnt_sh[i] || (!req_as[i] && !req_sh[i]));
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) state_q[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < 4; i++) state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE:  if (cmd_in[i] != 4'd0) state_d[i] = S_OP2;
                S_OP2:   state_d[i] = S_DLY;
                S_DLY:   state_d[i] = S_ARB;
                S_ARB:   if (done[i]) state_d[i] = S_IDLE;
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            resp_d[i] = 2'd0;
            data_d[i] = 32'd0;
            if (done[i]) {resp_d[i], data_d[i]} = execute(cmd_q[i], op1_q[i], op2_q[i]);
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cmd_q[i]  <= 4'd0;
                op1_q[i]  <= 32'd0;
                op2_q[i]  <= 32'd0;
                resp_q[i] <= 2'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (state_q[i] == S_IDLE && cmd_in[i] != 4'd0) begin
                    cmd_q[i] <= cmd_in[i];
                    op1_q[i] <= data_in[i];
                end
                if (state_q[i] == S_OP2) op2_q[i] <= data_in[i];
                resp_q[i] <= resp_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_resp1 = resp_q[0];
    assign out_resp2 = resp_q[1];
    assign out_resp3 = resp_q[2];
    assign out_resp4 = resp_q[3];
    assign out_data1 = data_q[0];
    assign out_data2 = data_q[1];
    assign out_data3 = data_q[2];
    assign out_data4 = data_q[3];

endmodule

// File: tb/tb_calc1_top.sv
// tb/tb_calc1_top.sv - directed self-checking bench for calc1_top
module tb_calc1_top;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  cmd_r [4];
    logic [31:0] dat_r [4];
    logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
    logic [31:0] out_data1, out_data2, out_data3, out_data4;
    logic [1:0]  resp_w [4];
    logic [31:0] data_w [4];
    int checks = 0;
    int errors = 0;

    always #5 c_clk = ~c_clk;

    calc1_top dut (
        .c_clk(c_clk), .reset(reset),
        .req1_cmd_in(cmd_r[0]), .req2_cmd_in(cmd_r[1]),
        .req3_cmd_in(cmd_r[2]), .req4_cmd_in(cmd_r[3]),
        .req1_data_in(dat_r[0]), .req2_data_in(dat_r[1]),
        .req3_data_in(dat_r[2]), .req4_data_in(dat_r[3]),
        .out_resp1(out_resp1), .out_resp2(out_resp2),
        .out_resp3(out_resp3), .out_resp4(out_resp4),
        .out_data1(out_data1), .out_data2(out_data2),
        .out_data3(out_data3), .out_data4(out_data4)
    );

    assign resp_w[0] = out_resp1;
    assign resp_w[1] = out_resp2;
    assign resp_w[2] = out_resp3;
    assign resp_w[3] = out_resp4;
    assign data_w[0] = out_data1;
    assign data_w[1] = out_data2;
    assign data_w[2] = out_data3;
    assign data_w[3] = out_data4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("%s resp%0d", tag, j + 1), 32'(resp_w[j]), 32'd0);
            check($sformatf("%s data%0d", tag, j + 1), data_w[j], 32'd0);
        end
    endtask

    // Single request on one port; response must appear after edge T+3 for one cycle.
    task automatic run_one(input string tag, input int p, input logic [3:0] cmd,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] er, input logic [31:0] ed);
        cmd_r[p] = cmd;
        dat_r[p] = a;
        tick();
        cmd_r[p] = 4'd0;
        dat_r[p] = b;
        tick();
        dat_r[p] = 32'd0;
        tick();
        check({tag, " early"}, 32'(resp_w[p]), 32'd0);
        tick();
        check({tag, " resp"}, 32'(resp_w[p]), 32'(er));
        check({tag, " data"}, data_w[p], ed);
        tick();
        check({tag, " resp clr"}, 32'(resp_w[p]), 32'd0);
        check({tag, " data clr"}, data_w[p], 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cmd_r[j] = 4'd1;
            dat_r[j] = 32'h1234;
        end
        tick();
        tick();
        check_idle("reset");
        for (int j = 0; j < 4; j++) begin
            cmd_r[j] = 4'd0;
            dat_r[j] = 32'd0;
        end
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check_idle("post reset");

        run_one("add5+7", 0, 4'd1, 32'h5, 32'h7, 2'd1, 32'hC);
        run_one("add ovf", 1, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0);
        run_one("add msb", 1, 4'd1, 32'h7FFF_FFFF, 32'h1, 2'd1, 32'h8000_0000);
        run_one("sub 3-5", 2, 4'd2, 32'h3, 32'h5, 2'd2, 32'h0);
        run_one("sub 9-9", 2, 4'd2, 32'h9, 32'h9, 2'd1, 32'h0);
        run_one("sub 10-3", 2, 4'd2, 32'hA, 32'h3, 2'd1, 32'h7);
        run_one("shl", 3, 4'd5, 32'h1, 32'h24, 2'd1, 32'h10);
        run_one("shr", 3, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'h1);
        run_one("inv4", 0, 4'd4, 32'h5, 32'h7, 2'd3, 32'h0);
        run_one("inv15", 1, 4'd15, 32'hFF, 32'h1, 2'd3, 32'h0);

        // All four ports add together: port order sets latency 3,4,5,6.
        for (int j = 0; j < 4; j++) begin
            cmd_r[j] = 4'd1;
            dat_r[j] = 32'h100 * (j + 1);
        end
        tick();
        for (int j = 0; j < 4; j++) begin
            cmd_r[j] = 4'd0;
            dat_r[j] = j + 1;
        end
        tick();
        for (int j = 0; j < 4; j++) dat_r[j] = 32'd0;
        tick();
        check_idle("arb T+2");
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int j = 0; j < 4; j++) begin
                check($sformatf("arb c%0d resp%0d", k, j + 1), 32'(resp_w[j]), (j == k) ? 32'd1 : 32'd0);
                check($sformatf("arb c%0d data%0d", k, j + 1), data_w[j], (j == k) ? 32'h101 * (j + 1) : 32'd0);
            end
        end
        tick();
        check_idle("arb done");

        // Add on port 1 and shift on port 2 use different units: both at latency 3.
        cmd_r[0] = 4'd1; dat_r[0] = 32'h1;
        cmd_r[1] = 4'd5; dat_r[1] = 32'h3;
        tick();
        cmd_r[0] = 4'd0; dat_r[0] = 32'h1;
        cmd_r[1] = 4'd0; dat_r[1] = 32'h2;
        tick();
        dat_r[0] = 32'd0; dat_r[1] = 32'd0;
        cmd_r[0] = 4'd2;
        tick();
        cmd_r[0] = 4'd0;
        tick();
        check("indep resp1", 32'(out_resp1), 32'd1);
        check("indep data1", out_data1, 32'h2);
        check("indep resp2", 32'(out_resp2), 32'd1);
        check("indep data2", out_data2, 32'hC);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_idle($sformatf("busy ignore c%0d", k));
        end

        // Reset pulse after operand 2 aborts the request.
        cmd_r[0] = 4'd1; dat_r[0] = 32'h11;
        tick();
        cmd_r[0] = 4'd0; dat_r[0] = 32'h22;
        tick();
        dat_r[0] = 32'd0;
        reset = 1'b0;
        #1;
        check_idle("abort during");
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_idle($sformatf("abort c%0d", k));
        end
        run_one("after abort", 0, 4'd1, 32'h2, 32'h3, 2'd1, 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
